// File: rtl/hex_entry_pad.sv
// Four-button hex entry pad: synchronize and debounce the buttons, edit a 4-digit
// buffer under a cursor, and hand committed values out over a valid/ready handshake.
module hex_entry_pad #(
  parameter int DB_LIMIT = 500000,
  parameter int DB_W     = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc_n,
  input  logic        btn_next_n,
  input  logic        btn_clear_n,
  input  logic        btn_commit_n,
  output logic [15:0] digits,
  output logic [1:0]  cursor,
  output logic [3:0]  cursor_onehot,
  output logic [3:0]  pressed,
  output logic [15:0] entry_data,
  output logic        entry_valid,
  input  logic        entry_ready,
  output logic        overrun
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] CNT_ZERO = DB_W'(0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Bit order everywhere is {commit, clear, next, inc}.
  logic [3:0]           btn_n_s;
  logic [3:0]           sync1_q;
  logic [3:0]           sync2_q;
  logic [3:0]           stable_q;
  logic [3:0]           stable_d;
  logic [3:0][DB_W-1:0] cnt_q;
  logic [3:0][DB_W-1:0] cnt_d;
  logic [3:0]           fall_s;

  logic act_clear_s;
  logic act_commit_s;
  logic act_inc_s;
  logic act_next_s;

  logic [15:0] digits_q;
  logic [15:0] digits_d;
  logic [1:0]  cursor_q;
  logic [1:0]  cursor_d;
  logic [3:0]  onehot_q;
  logic [3:0]  onehot_d;
  logic [15:0] data_q;
  logic [15:0] data_d;
  logic        overrun_q;
  logic        overrun_d;
  state_e      state_q;
  state_e      state_d;

  assign btn_n_s = {btn_commit_n, btn_clear_n, btn_next_n, btn_inc_n};

  // Synchronizer and debounce state; everything resets to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      stable_q <= 4'hF;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q  <= btn_n_s;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // The press pulse is decoded from the accepting count so edits land on the
  // same edge the stable level flips.
  always_comb begin
    stable_d = stable_q;
    fall_s   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          fall_s[i]   = ~sync2_q[i];
          cnt_d[i]    = CNT_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = CNT_ZERO;
      end
    end
  end

  assign act_clear_s  = fall_s[2];
  assign act_commit_s = fall_s[3] & ~fall_s[2];
  assign act_inc_s    = fall_s[0] & ~fall_s[2] & ~fall_s[3];
  assign act_next_s   = fall_s[1] & ~fall_s[0] & ~fall_s[2] & ~fall_s[3];

  always_comb begin
    digits_d = digits_q;
    cursor_d = cursor_q;
    onehot_d = onehot_q;
    if (act_clear_s) begin
      digits_d = 16'h0000;
      cursor_d = 2'd0;
      onehot_d = 4'b0001;
    end else if (act_inc_s) begin
      case (cursor_q)
        2'd0:    digits_d[15:12] = digits_q[15:12] + 4'd1;
        2'd1:    digits_d[11:8]  = digits_q[11:8]  + 4'd1;
        2'd2:    digits_d[7:4]   = digits_q[7:4]   + 4'd1;
        2'd3:    digits_d[3:0]   = digits_q[3:0]   + 4'd1;
        default: digits_d        = digits_q;
      endcase
    end else if (act_next_s) begin
      cursor_d = cursor_q + 2'd1;
      onehot_d = {onehot_q[2:0], onehot_q[3]};
    end else begin
      digits_d = digits_q;
    end
  end

  // Handshake: a commit while a value is still pending and not being taken is dropped.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (act_clear_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (act_commit_s) begin
          data_d  = digits_q;
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (entry_ready) begin
          if (act_commit_s) begin
            data_d  = digits_q;
            state_d = ST_PEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (act_commit_s) begin
          overrun_d = 1'b1;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q  <= 16'h0000;
      cursor_q  <= 2'd0;
      onehot_q  <= 4'b0001;
      data_q    <= 16'h0000;
      overrun_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      digits_q  <= digits_d;
      cursor_q  <= cursor_d;
      onehot_q  <= onehot_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign digits        = digits_q;
  assign cursor        = cursor_q;
  assign cursor_onehot = onehot_q;
  assign pressed       = ~stable_q;
  assign entry_data    = data_q;
  assign entry_valid   = (state_q == ST_PEND);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_hex_entry_pad.sv
// Directed bench for hex_entry_pad with DB_LIMIT = 4: a press lands 6 cycles after
// the pin falls, and a release settles 6 cycles after the pin rises.
module tb_hex_entry_pad;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn_n = 4'hF;   // {commit, clear, next, inc}
  logic        entry_ready = 1'b0;
  logic [15:0] digits;
  logic [1:0]  cursor;
  logic [3:0]  cursor_onehot;
  logic [3:0]  pressed;
  logic [15:0] entry_data;
  logic        entry_valid;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] B_INC    = 4'b0001;
  localparam logic [3:0] B_NEXT   = 4'b0010;
  localparam logic [3:0] B_CLEAR  = 4'b0100;
  localparam logic [3:0] B_COMMIT = 4'b1000;

  hex_entry_pad #(.DB_LIMIT(4), .DB_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_inc_n    (btn_n[0]),
    .btn_next_n   (btn_n[1]),
    .btn_clear_n  (btn_n[2]),
    .btn_commit_n (btn_n[3]),
    .digits       (digits),
    .cursor       (cursor),
    .cursor_onehot(cursor_onehot),
    .pressed      (pressed),
    .entry_data   (entry_data),
    .entry_valid  (entry_valid),
    .entry_ready  (entry_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pin low, optional one-cycle ready on the accepting edge, then release and settle.
  task automatic press(input logic [3:0] mask, input bit rdy_on_fire);
    btn_n = btn_n & ~mask;
    repeat (5) tick();
    if (rdy_on_fire) entry_ready = 1'b1;
    tick();
    entry_ready = 1'b0;
    btn_n = 4'hF;
    repeat (7) tick();
  endtask

  task automatic press_n(input logic [3:0] mask, input int n);
    for (int k = 0; k < n; k++) press(mask, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_digits"}, {16'h0, digits}, 32'h0);
    check_eq({tag, "_cursor"}, {30'h0, cursor}, 32'h0);
    check_eq({tag, "_onehot"}, {28'h0, cursor_onehot}, 32'h1);
    check_eq({tag, "_pressed"}, {28'h0, pressed}, 32'h0);
    check_eq({tag, "_edata"}, {16'h0, entry_data}, 32'h0);
    check_eq({tag, "_evalid"}, {31'h0, entry_valid}, 32'h0);
    check_eq({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
  endtask

  initial begin
    bit saw_press;
    bit saw_edit;

    rst = 1'b1;
    repeat (2) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // 1. Bounce rejection
    saw_press = 1'b0;
    saw_edit  = 1'b0;
    btn_n[0] = 1'b0;
    repeat (3) begin tick(); saw_press |= pressed[0]; saw_edit |= (digits != 16'h0); end
    btn_n[0] = 1'b1;
    tick(); saw_press |= pressed[0]; saw_edit |= (digits != 16'h0);
    btn_n[0] = 1'b0;
    repeat (3) begin tick(); saw_press |= pressed[0]; saw_edit |= (digits != 16'h0); end
    btn_n[0] = 1'b1;
    repeat (8) begin tick(); saw_press |= pressed[0]; saw_edit |= (digits != 16'h0); end
    check_eq("bounce_pressed", {31'h0, saw_press}, 32'h0);
    check_eq("bounce_digits", {31'h0, saw_edit}, 32'h0);

    btn_n[0] = 1'b0;
    repeat (5) tick();
    check_eq("hold_before6", {16'h0, digits}, 32'h0);
    tick();
    check_eq("hold_at6", {16'h0, digits}, 32'h1000);
    check_eq("hold_pressed", {28'h0, pressed}, 32'h1);
    repeat (4) tick();
    btn_n[0] = 1'b1;
    repeat (7) tick();
    check_eq("hold_single_inc", {16'h0, digits}, 32'h1000);
    check_eq("release_pressed", {28'h0, pressed}, 32'h0);

    // 2. Wrap-around
    press(B_CLEAR, 1'b0);
    check_eq("clear_digits", {16'h0, digits}, 32'h0);
    press_n(B_INC, 15);
    check_eq("inc15", {16'h0, digits}, 32'hF000);
    press(B_INC, 1'b0);
    check_eq("inc16_wrap", {16'h0, digits}, 32'h0);
    press_n(B_NEXT, 5);
    check_eq("next5_cursor", {30'h0, cursor}, 32'h1);
    check_eq("next5_onehot", {28'h0, cursor_onehot}, 32'h2);
    press(B_INC, 1'b0);
    check_eq("inc_digit1", {16'h0, digits}, 32'h0100);

    // 3. Commit and handshake
    press(B_CLEAR, 1'b0);
    press_n(B_INC, 1);
    press(B_NEXT, 1'b0);
    press_n(B_INC, 2);
    press(B_NEXT, 1'b0);
    press_n(B_INC, 10);
    press(B_NEXT, 1'b0);
    press_n(B_INC, 11);
    check_eq("build_12ab", {16'h0, digits}, 32'h12AB);
    press(B_COMMIT, 1'b0);
    check_eq("commit_valid", {31'h0, entry_valid}, 32'h1);
    check_eq("commit_data", {16'h0, entry_data}, 32'h12AB);
    repeat (3) tick();
    check_eq("commit_data_held", {16'h0, entry_data}, 32'h12AB);
    check_eq("commit_valid_held", {31'h0, entry_valid}, 32'h1);
    entry_ready = 1'b1;
    tick();
    entry_ready = 1'b0;
    check_eq("ready_valid_low", {31'h0, entry_valid}, 32'h0);
    check_eq("ready_digits_kept", {16'h0, digits}, 32'h12AB);
    check_eq("ready_cursor_kept", {30'h0, cursor}, 32'h3);

    // 4. Overrun
    press(B_CLEAR, 1'b0);
    press_n(B_NEXT, 3);
    press(B_INC, 1'b0);
    check_eq("build_0001", {16'h0, digits}, 32'h0001);
    press(B_COMMIT, 1'b0);
    press(B_INC, 1'b0);
    check_eq("edit_0002", {16'h0, digits}, 32'h0002);
    press(B_COMMIT, 1'b0);
    check_eq("ovr_data", {16'h0, entry_data}, 32'h0001);
    check_eq("ovr_flag", {31'h0, overrun}, 32'h1);
    check_eq("ovr_valid", {31'h0, entry_valid}, 32'h1);
    press(B_CLEAR, 1'b0);
    check_eq("clr_overrun", {31'h0, overrun}, 32'h0);
    check_eq("clr_digits", {16'h0, digits}, 32'h0);
    check_eq("clr_valid_kept", {31'h0, entry_valid}, 32'h1);
    check_eq("clr_data_kept", {16'h0, entry_data}, 32'h0001);

    // 5. Simultaneous events
    press(B_INC | B_NEXT, 1'b0);
    check_eq("sim_digits", {16'h0, digits}, 32'h1000);
    check_eq("sim_cursor", {30'h0, cursor}, 32'h0);
    press(B_COMMIT, 1'b1);
    check_eq("pend_commit_data", {16'h0, entry_data}, 32'h1000);
    check_eq("pend_commit_valid", {31'h0, entry_valid}, 32'h1);
    check_eq("pend_commit_ovr", {31'h0, overrun}, 32'h0);

    // 6. Reset mid-operation
    press(B_CLEAR, 1'b0);
    press(B_NEXT, 1'b0);
    press_n(B_INC, 15);
    press_n(B_NEXT, 2);
    press_n(B_INC, 15);
    check_eq("build_0f0f", {16'h0, digits}, 32'h0F0F);
    check_eq("pre_rst_valid", {31'h0, entry_valid}, 32'h1);
    btn_n[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (5) tick();
    check_eq("postrst_before6", {16'h0, digits}, 32'h0);
    tick();
    check_eq("postrst_at6", {16'h0, digits}, 32'h1000);
    repeat (6) tick();
    btn_n[0] = 1'b1;
    repeat (7) tick();
    check_eq("postrst_single", {16'h0, digits}, 32'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
